// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement adder/subtractor with an accumulate mode, status flags
// and valid/ready handshakes; CHUNK bits are summed per cycle with a registered carry.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cy,
  output logic             out_ov,
  output logic             out_z,
  output logic             out_n,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] opa, opb, work, work_next;
  logic             carry;
  logic [KW-1:0]    k;
  logic [31:0]      base;
  logic [CHUNK:0]   chunk_sum;
  logic             last, accept, msb_cin;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_ready & in_valid;
  assign last   = (k == KW'(N - 1));

  // The MSB sum bit is a ^ b ^ cin, so the carry into the MSB falls out of the finished sum.
  always_comb begin
    base      = 32'(k) * 32'(CHUNK);
    chunk_sum = {1'b0, opa[base +: CHUNK]} + {1'b0, opb[base +: CHUNK]} + {{CHUNK{1'b0}}, carry};
    work_next = work;
    work_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    msb_cin   = work_next[WIDTH-1] ^ opa[WIDTH-1] ^ opb[WIDTH-1];
  end

  // out_s doubles as the accumulator R: it only changes when a result is completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      work   <= '0;
      carry  <= 1'b0;
      k      <= '0;
      out_s  <= '0;
      out_cy <= 1'b0;
      out_ov <= 1'b0;
      out_z  <= 1'b0;
      out_n  <= 1'b0;
    end else if (accept) begin
      opa   <= in_op[1] ? out_s : in_a;
      opb   <= in_b ^ {WIDTH{in_op[0]}};
      carry <= in_op[0];
      k     <= '0;
    end else if (state == RUN) begin
      work  <= work_next;
      carry <= chunk_sum[CHUNK];
      k     <= last ? '0 : k + 1'b1;
      if (last) begin
        out_s  <= work_next;
        out_cy <= chunk_sum[CHUNK];
        out_ov <= msb_cin ^ chunk_sum[CHUNK];
        out_z  <= (work_next == '0);
        out_n  <= work_next[WIDTH-1];
      end
    end
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor that processes CHUNK bits per clock with a registered carry between chunks, generalising the 4-bit combinational ripple add/sub to arbitrary width. It adds an accumulate mode, status flags and valid/ready handshakes on input and output. It sits between an operand source (register file or test controller) and a result consumer in the arithmetic lab datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK, at least 2.
- CHUNK, 4, bits processed per RUN cycle; N = WIDTH/CHUNK cycles per operation.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high; one clock, one synchronous active-high reset.
- in_a  input  WIDTH  operand A (ignored in accumulate modes).
- in_b  input  WIDTH  operand B.
- in_op  input  2  00 add A+B, 01 sub A-B, 10 acc-add R+B, 11 acc-sub R-B (R = last stored result).
- in_valid  input  1  operand/op valid.
- in_ready  output  1  block can accept; high only in IDLE.
- out_s  output  WIDTH  result.
- out_cy  output  1  carry out of MSB (for sub: 1 = no borrow).
- out_ov  output  1  signed overflow.
- out_z  output  1  result == 0.
- out_n  output  1  result MSB.
- out_valid  output  1  result and flags valid; high only in DONE.
- out_ready  input  1  consumer accepts result.

## Operation
- FSM states IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid & in_ready: latch first operand (in_a, or R if in_op[1]=1), latch B' = in_b XOR {WIDTH{in_op[0]}}, carry register = in_op[0], chunk index = 0; go to RUN.
- RUN: each cycle compute chunk k: {c, s[k*CHUNK +: CHUNK]} = A_k + B'_k + carry; store sum chunk, update carry, k++. On last chunk (k = N-1) record carry into MSB (internal) and carry out; go to DONE.
- DONE: out_valid=1, outputs stable; R updated to result on entry. On out_ready=1 go to IDLE.
- Flags: out_cy = final carry; out_ov = carry into MSB XOR carry out of MSB; out_z = (out_s==0); out_n = out_s[WIDTH-1].
- All arithmetic modulo 2^WIDTH; no saturation.
- in_valid in RUN/DONE ignored (in_ready=0); operands need not be held after acceptance.
- R persists across operations; cleared only by rst.

## Timing
- Reset values: in_ready=1 (first cycle after rst deasserts; 0 while rst high is not required—in_ready=1, out_valid=0 during reset), out_valid=0, out_s=0, out_cy=0, out_ov=0, out_z=0, out_n=0, R=0.
- Accept at edge E0; RUN occupies edges E0+1..E0+N; out_valid high from after edge E0+N.
- Result handed off at first edge in DONE with out_ready=1; in_ready high after that edge. Minimum interval between accepts: N+2 cycles.
- out_ready held high before DONE: DONE lasts exactly one cycle.
- out_s/flags hold value from DONE until next DONE entry (not cleared in IDLE).
- rst mid RUN or DONE: abort at that edge, all outputs and R to reset values, no out_valid for the aborted op.
- rst has priority over every other input on the same edge.

## Test plan
- WIDTH=16, CHUNK=4: add 0x1234+0x0FF0 -> out_s=0x2224, cy=0 ov=0 z=0 n=0, out_valid 4 cycles after accept edge.
- add 0x7FFF+0x0001 -> 0x8000, ov=1 n=1 cy=0; sub 0x0005-0x0005 -> 0x0000, cy=1 z=1 ov=0.
- sub 0x0003-0x0005 -> 0xFFFE, cy=0 n=1 ov=0; sub 0x8000-0x0001 -> 0x7FFF, ov=1 cy=1.
- Accumulate: add 0x7FFF+0x0001 (R=0x8000), then acc-add B=0x8000 -> 0x0000 cy=1 ov=1 z=1; then acc-sub B=0x0001 -> 0xFFFF cy=0 n=1.
- Backpressure: out_ready low 3 cycles in DONE -> out_valid and out_s stable, in_ready=0, in_valid pulses ignored; out_ready high -> in_ready=1 next cycle.
- rst asserted at second RUN cycle -> next cycle out_valid=0, in_ready=1, out_s=0; subsequent acc-add B=0x0005 -> 0x0005 (R cleared). Repeat add with WIDTH=8, CHUNK=8 (N=1) and WIDTH=12, CHUNK=3.
